msx_mouse_port_ctrl: RTL



---
 rtl/msx_mouse_port_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/msx_mouse_port_ctrl.sv
// -----------------------------------------------------------------------------
// msx_mouse_port_ctrl
//
// Owns MSX general-purpose port A and shares it between the MiST joystick and
// the PS/2 mouse. PS/2 deltas are accumulated into saturating signed
// accumulators. The MSX side reads them as four 4-bit nibbles, advancing one
// nibble on every edge (rising or falling) of the port strobe (pin 8).
//
// Ports:
//   clk_sys       in   1  system clock
//   reset_n       in   1  asynchronous active-low reset (release synchronised)
//   mouse_x       in   9  signed PS/2 X delta, valid on mouse_strobe
//   mouse_y       in   9  signed PS/2 Y delta, valid on mouse_strobe
//   mouse_btn     in   2  [0]=left, [1]=right, 1=pressed
//   mouse_strobe  in   1  one-cycle pulse, new mouse packet
//   joy_n         in   6  joystick, active-low ([3:0]=R,L,D,U, [5:4]=B,A)
//   port_str      in   1  raw strobe from the MSX PSG (asynchronous)
//   port_out      out  6  level presented to the MSX pins, 1=released
//   mouse_active  out  1  mode FSM state: 1 = port in mouse mode
//   phase         out  2  index of the next nibble to be sent
// -----------------------------------------------------------------------------
module msx_mouse_port_ctrl #(
  parameter int TIMEOUT = 100000,
  parameter int SAT_W   = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic signed [8:0] mouse_x,
  input  logic signed [8:0] mouse_y,
  input  logic [1:0]        mouse_btn,
  input  logic              mouse_strobe,
  input  logic [5:0]        joy_n,
  input  logic              port_str,
  output logic [5:0]        port_out,
  output logic              mouse_active,
  output logic [1:0]        phase
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EXT_W = SAT_W + 2;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (SAT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (SAT_W - 1)));

  typedef enum logic {
    MODE_JOY   = 1'b0,
    MODE_MOUSE = 1'b1
  } mode_e;

  function automatic logic [SAT_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[SAT_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[SAT_W-1:0];
    end else begin
      return v[SAT_W-1:0];
    end
  endfunction

  // Reset: asserts immediately, releases two clk_sys edges after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Strobe synchroniser plus edge-detect flop; either edge is an event.
  logic str_meta_q, str_sync_q, str_prev_q;
  logic str_event;

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      str_meta_q <= 1'b0;
      str_sync_q <= 1'b0;
      str_prev_q <= 1'b0;
    end else begin
      str_meta_q <= port_str;
      str_sync_q <= str_meta_q;
      str_prev_q <= str_sync_q;
    end
  end

  assign str_event = str_sync_q ^ str_prev_q;

  // State
  mode_e             mode_q, mode_d;
  logic [SAT_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [SAT_W-1:0]  snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        port_q, port_d;

  // X is accumulated with inverted sign so that right-hand motion reads as
  // the MSX convention expects.
  logic signed [EXT_W-1:0] ax_ext, ay_ext, mx_ext, my_ext;
  logic [SAT_W-1:0]        acc_x_upd, acc_y_upd, acc_x_fresh, acc_y_fresh;

  assign ax_ext      = {{2{acc_x_q[SAT_W-1]}}, acc_x_q};
  assign ay_ext      = {{2{acc_y_q[SAT_W-1]}}, acc_y_q};
  assign mx_ext      = {{(EXT_W-9){mouse_x[8]}}, mouse_x};
  assign my_ext      = {{(EXT_W-9){mouse_y[8]}}, mouse_y};
  assign acc_x_upd   = sat(ax_ext - mx_ext);
  assign acc_y_upd   = sat(ay_ext + my_ext);
  assign acc_x_fresh = sat(-mx_ext);
  assign acc_y_fresh = sat(my_ext);

  always_comb begin
    mode_d   = mode_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    port_d   = port_q;

    if (mouse_strobe) begin
      acc_x_d = acc_x_upd;
      acc_y_d = acc_y_upd;
    end

    // Mode FSM: a mouse packet always wins over joystick activity.
    case (mode_q)
      MODE_JOY:   if (mouse_strobe) mode_d = MODE_MOUSE;
      MODE_MOUSE: if (!mouse_strobe && joy_n != 6'h3F) mode_d = MODE_JOY;
      default:    mode_d = MODE_JOY;
    endcase

    if (mode_q == MODE_MOUSE && mode_d == MODE_JOY) begin
      acc_x_d  = '0;
      acc_y_d  = '0;
      snap_x_d = '0;
      snap_y_d = '0;
      phase_d  = 2'd0;
      cnt_d    = '0;
    end else if (mode_q == MODE_MOUSE && str_event) begin
      cnt_d   = CNT_W'(TIMEOUT);
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd0: begin
          // Phase 0 sends straight from the accumulator being snapshotted,
          // and a coincident packet seeds the emptied accumulator.
          port_d[3:0] = acc_x_q[7:4];
          snap_x_d    = acc_x_q;
          snap_y_d    = acc_y_q;
          acc_x_d     = mouse_strobe ? acc_x_fresh : '0;
          acc_y_d     = mouse_strobe ? acc_y_fresh : '0;
        end
        2'd1:    port_d[3:0] = snap_x_q[3:0];
        2'd2:    port_d[3:0] = snap_y_q[7:4];
        default: port_d[3:0] = snap_y_q[3:0];
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        phase_d = 2'd0;
      end
    end

    // Output register selects on the next mode so the pins follow the
    // joystick in the same cycle that mouse_active drops.
    if (mode_d == MODE_MOUSE) begin
      port_d[5:4] = ~{mouse_btn[1], mouse_btn[0]};
    end else begin
      port_d = str_sync_q ? 6'h3F : joy_n;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      mode_q   <= MODE_JOY;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      phase_q  <= 2'd0;
      cnt_q    <= '0;
      port_q   <= 6'h3F;
    end else begin
      mode_q   <= mode_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
    end
  end

  assign port_out     = port_q;
  assign mouse_active = (mode_q == MODE_MOUSE);
  assign phase        = phase_q;

endmodule
